// File: rtl/stream_grant_arbiter_pkg.sv
// ============================================================================
//  Module  : crossbar_pkg
//  Brief   : Shared counts, widths, arbiter FSM encoding and rotation helper.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package crossbar_pkg;

    localparam int DEF_S_DATA_COUNT = 2;
    localparam int DEF_M_DATA_COUNT = 3;
    localparam int DEF_T_ID___WIDTH = $clog2(DEF_S_DATA_COUNT);
    localparam int DEF_T_DEST_WIDTH = $clog2(DEF_M_DATA_COUNT);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Rotational distance of idx past ptr: ptr+1 -> 0, ..., ptr -> n-1.
    function automatic int rr_distance(input int idx, input int ptr, input int n);
        return (idx - ptr - 1 + 2 * n) % n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/stream_grant_arbiter_if.sv
// ============================================================================
//  Module  : stream_grant_arbiter_if
//  Brief   : Request/handshake bundle between the stream masters and the
//            per-destination grant arbiter.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface stream_grant_arbiter_if #(
    parameter int S_DATA_COUNT = crossbar_pkg::DEF_S_DATA_COUNT,
    parameter int M_DATA_COUNT = crossbar_pkg::DEF_M_DATA_COUNT,
    parameter int T_ID___WIDTH = $clog2(S_DATA_COUNT),
    parameter int T_DEST_WIDTH = $clog2(M_DATA_COUNT)
);

    logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0] s_dest_i;
    logic [S_DATA_COUNT-1:0]                   s_valid_i;
    logic [S_DATA_COUNT-1:0]                   s_last_i;
    logic [M_DATA_COUNT-1:0]                   m_ready_i;
    logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0] grant_o;
    logic [M_DATA_COUNT-1:0]                   grant_valid_o;

    modport master (
        output s_dest_i,
        output s_valid_i,
        output s_last_i,
        output m_ready_i,
        input  grant_o,
        input  grant_valid_o
    );

    modport slave (
        input  s_dest_i,
        input  s_valid_i,
        input  s_last_i,
        input  m_ready_i,
        output grant_o,
        output grant_valid_o
    );

endinterface

`default_nettype wire

// File: rtl/stream_grant_arbiter_rr_arbiter.sv
// ============================================================================
//  Module  : stream_rr_arbiter
//  Brief   : Packet-locking round-robin arbiter for one destination slave.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module stream_rr_arbiter
    import crossbar_pkg::*;
#(
    parameter int S_DATA_COUNT = DEF_S_DATA_COUNT,
    parameter int T_ID___WIDTH = $clog2(S_DATA_COUNT)
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [S_DATA_COUNT-1:0] req_i,
    input  logic                    ready_i,
    input  logic [S_DATA_COUNT-1:0] last_i,
    output logic [T_ID___WIDTH-1:0] grant_o,
    output logic                    grant_valid_o
);

    localparam logic [0:0]              ST_IDLE   = IDLE;
    localparam logic [0:0]              ST_LOCKED = LOCKED;
    localparam logic [T_ID___WIDTH-1:0] PTR_RESET = T_ID___WIDTH'(S_DATA_COUNT - 1);

    logic [0:0]              state_q, state_d;
    logic [T_ID___WIDTH-1:0] grant_q, grant_d;
    logic [T_ID___WIDTH-1:0] ptr_q,   ptr_d;

    logic                    pick_found;
    logic [T_ID___WIDTH-1:0] pick_idx;
    int                      best_dist;
    logic                    pkt_done;

    // Closest requester after the pointer wins; master ptr itself is last.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        best_dist  = S_DATA_COUNT;
        for (int i = 0; i < S_DATA_COUNT; i++) begin
            if (req_i[i] && (rr_distance(i, int'(ptr_q), S_DATA_COUNT) < best_dist)) begin
                best_dist  = rr_distance(i, int'(ptr_q), S_DATA_COUNT);
                pick_idx   = T_ID___WIDTH'(i);
                pick_found = 1'b1;
            end
        end
    end

    // req_i already folds in valid and destination match of the owner.
    assign pkt_done = req_i[grant_q] && ready_i && last_i[grant_q];

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (pkt_done) begin
                    ptr_d   = grant_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= PTR_RESET;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant_o       = grant_q;
    assign grant_valid_o = (state_q == ST_LOCKED);

endmodule

`default_nettype wire

// File: rtl/stream_grant_arbiter.sv
// ============================================================================
//  Module  : stream_grant_arbiter
//  Brief   : Crossbar grant stage; one packet-locking arbiter per slave.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module stream_grant_arbiter
    import crossbar_pkg::*;
#(
    parameter int S_DATA_COUNT = DEF_S_DATA_COUNT,
    parameter int M_DATA_COUNT = DEF_M_DATA_COUNT,
    parameter int T_ID___WIDTH = $clog2(S_DATA_COUNT),
    parameter int T_DEST_WIDTH = $clog2(M_DATA_COUNT)
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    stream_grant_arbiter_if.slave bus
);

    logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0] req;

    for (genvar j = 0; j < M_DATA_COUNT; j++) begin : g_slave
        localparam logic [T_DEST_WIDTH-1:0] DEST_ID = T_DEST_WIDTH'(j);

        for (genvar i = 0; i < S_DATA_COUNT; i++) begin : g_req
            assign req[j][i] = bus.s_valid_i[i] && (bus.s_dest_i[i] == DEST_ID);
        end

        stream_rr_arbiter #(
            .S_DATA_COUNT (S_DATA_COUNT),
            .T_ID___WIDTH (T_ID___WIDTH)
        ) u_arb (
            .clk_i         (clk_i),
            .rst_n_i       (rst_n_i),
            .req_i         (req[j]),
            .ready_i       (bus.m_ready_i[j]),
            .last_i        (bus.s_last_i),
            .grant_o       (bus.grant_o[j]),
            .grant_valid_o (bus.grant_valid_o[j])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_stream_grant_arbiter.sv
// ============================================================================
//  Module  : tb_stream_grant_arbiter
//  Brief   : Directed-vector bench with a cycle-stamped expectation queue.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_stream_grant_arbiter;

    localparam int S = 2;
    localparam int M = 3;

    logic clk_i   = 1'b0;
    logic rst_n_i = 1'b1;

    always #5 clk_i = ~clk_i;

    stream_grant_arbiter_if #(
        .S_DATA_COUNT (S),
        .M_DATA_COUNT (M),
        .T_ID___WIDTH (1),
        .T_DEST_WIDTH (2)
    ) bus ();

    stream_grant_arbiter #(
        .S_DATA_COUNT (S),
        .M_DATA_COUNT (M),
        .T_ID___WIDTH (1),
        .T_DEST_WIDTH (2)
    ) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
    );

    typedef struct {
        int         cyc;
        logic [2:0] gv;
        logic [2:0] g;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         cyc    = 0;
    int         checks = 0;
    int         errors = 0;
    logic [2:0] g_act;

    assign g_act = bus.grant_o;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic cmp(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%b expected=%b", name, cyc, act, exp);
        end
    endtask

    // Apply one input vector; outputs after the next edge must match egv/eg.
    task automatic vec(input logic [1:0] d0, input logic [1:0] d1,
                       input logic [1:0] v,  input logic [1:0] l,
                       input logic [2:0] r,  input logic [2:0] egv,
                       input logic [2:0] eg);
        exp_t e;
        bus.s_dest_i  = {d1, d0};
        bus.s_valid_i = v;
        bus.s_last_i  = l;
        bus.m_ready_i = r;
        e.cyc = cyc + 1;
        e.gv  = egv;
        e.g   = eg;
        exp_q.push_back(e);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        bus.s_dest_i  = '0;
        bus.s_valid_i = '0;
        bus.s_last_i  = '0;
        bus.m_ready_i = '0;

        fork
            forever begin
                @(negedge clk_i);
                if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                    mon_e = exp_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL stale_expectation cyc=%0d got=none expected=cyc%0d", cyc, mon_e.cyc);
                end else if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
                    mon_e = exp_q.pop_front();
                    cmp("grant_valid", bus.grant_valid_o, mon_e.gv);
                    cmp("grant", g_act, mon_e.g);
                end
            end
        join_none

        #1 rst_n_i = 1'b0;
        #2;
        cmp("reset_grant_valid", bus.grant_valid_o, 3'b000);
        cmp("reset_grant", g_act, 3'b000);
        @(posedge clk_i);
        #3 rst_n_i = 1'b1;

        // Master 0 -> slave 1, three beats
        vec(2'd1, 2'd0, 2'b01, 2'b00, 3'b010, 3'b010, 3'b000);
        vec(2'd1, 2'd0, 2'b01, 2'b00, 3'b010, 3'b010, 3'b000);
        vec(2'd1, 2'd0, 2'b01, 2'b00, 3'b010, 3'b010, 3'b000);
        vec(2'd1, 2'd0, 2'b01, 2'b01, 3'b010, 3'b000, 3'b000);
        vec(2'd0, 2'd0, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000);

        // Both masters -> slave 2, two-beat packets alternate with a bubble
        vec(2'd2, 2'd2, 2'b11, 2'b00, 3'b100, 3'b100, 3'b000);
        vec(2'd2, 2'd2, 2'b11, 2'b00, 3'b100, 3'b100, 3'b000);
        vec(2'd2, 2'd2, 2'b11, 2'b01, 3'b100, 3'b000, 3'b000);
        vec(2'd2, 2'd2, 2'b11, 2'b00, 3'b100, 3'b100, 3'b100);
        vec(2'd2, 2'd2, 2'b11, 2'b00, 3'b100, 3'b100, 3'b100);
        vec(2'd2, 2'd2, 2'b11, 2'b10, 3'b100, 3'b000, 3'b100);
        vec(2'd2, 2'd2, 2'b11, 2'b00, 3'b100, 3'b100, 3'b000);
        vec(2'd2, 2'd2, 2'b11, 2'b00, 3'b100, 3'b100, 3'b000);
        vec(2'd2, 2'd2, 2'b11, 2'b01, 3'b100, 3'b000, 3'b000);
        vec(2'd2, 2'd2, 2'b11, 2'b00, 3'b100, 3'b100, 3'b100);
        vec(2'd2, 2'd2, 2'b10, 2'b10, 3'b100, 3'b000, 3'b100);

        // Concurrent grants on slaves 0 and 2
        vec(2'd0, 2'd2, 2'b11, 2'b00, 3'b000, 3'b101, 3'b100);
        vec(2'd0, 2'd2, 2'b11, 2'b11, 3'b101, 3'b000, 3'b100);

        // Lock held through valid drop and ready toggling
        vec(2'd0, 2'd1, 2'b10, 2'b00, 3'b000, 3'b010, 3'b110);
        vec(2'd1, 2'd1, 2'b11, 2'b00, 3'b010, 3'b010, 3'b110);
        vec(2'd1, 2'd1, 2'b01, 2'b01, 3'b000, 3'b010, 3'b110);
        vec(2'd1, 2'd1, 2'b01, 2'b01, 3'b010, 3'b010, 3'b110);
        vec(2'd1, 2'd1, 2'b01, 2'b01, 3'b000, 3'b010, 3'b110);
        vec(2'd1, 2'd1, 2'b01, 2'b01, 3'b010, 3'b010, 3'b110);
        vec(2'd1, 2'd1, 2'b11, 2'b10, 3'b010, 3'b000, 3'b110);
        vec(2'd1, 2'd0, 2'b01, 2'b00, 3'b010, 3'b010, 3'b100);
        vec(2'd1, 2'd0, 2'b01, 2'b01, 3'b010, 3'b000, 3'b100);

        // Asynchronous reset in the middle of a packet
        vec(2'd0, 2'd0, 2'b10, 2'b00, 3'b000, 3'b001, 3'b101);
        #5 rst_n_i = 1'b0;
        #1;
        cmp("midreset_grant_valid", bus.grant_valid_o, 3'b000);
        cmp("midreset_grant", g_act, 3'b000);
        @(posedge clk_i);
        @(posedge clk_i);
        #3 rst_n_i = 1'b1;
        vec(2'd0, 2'd0, 2'b11, 2'b00, 3'b000, 3'b001, 3'b000);
        vec(2'd0, 2'd0, 2'b01, 2'b01, 3'b001, 3'b000, 3'b000);

        // Single-beat packets on slave 1
        vec(2'd1, 2'd1, 2'b11, 2'b11, 3'b010, 3'b010, 3'b000);
        vec(2'd1, 2'd1, 2'b11, 2'b11, 3'b010, 3'b000, 3'b000);
        vec(2'd1, 2'd1, 2'b11, 2'b11, 3'b010, 3'b010, 3'b010);
        vec(2'd1, 2'd1, 2'b11, 2'b11, 3'b010, 3'b000, 3'b010);
        vec(2'd1, 2'd1, 2'b11, 2'b11, 3'b010, 3'b010, 3'b000);
        vec(2'd1, 2'd1, 2'b11, 2'b11, 3'b010, 3'b000, 3'b000);
        vec(2'd0, 2'd0, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000);

        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
